// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: turns single load/store requests into registered,
// fixed-length read/write strobes and returns the loaded byte zero-extended to 16 bits.
module dmem_access_ctrl #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [15:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [7:0]        mem_rdata
);

    // 0 behaves as 1; anything above the 4-bit counter range saturates at 15
    localparam int unsigned WAIT_EFF = (WAIT_CYCLES == 0) ? 1 :
                                       (WAIT_CYCLES > 15) ? 15 : WAIT_CYCLES;
    localparam int unsigned CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_EFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              busy_nx, done_nx, rd_nx, wr_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [7:0]        wdata_nx;
    logic [15:0]       rdata_nx;

    // Only the low byte of wdata reaches the byte-wide memory
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^wdata[15:8];

    // State and output registers; strobes leave the block straight from these flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            rdata     <= 16'h0000;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            mem_rd    <= rd_nx;
            mem_wr    <= wr_nx;
            mem_addr  <= addr_nx;
            mem_wdata <= wdata_nx;
            rdata     <= rdata_nx;
        end
    end

    // Next-state and next-output logic; address/data/rdata hold unless updated
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        busy_nx  = busy;
        done_nx  = 1'b0;
        rd_nx    = mem_rd;
        wr_nx    = mem_wr;
        addr_nx  = mem_addr;
        wdata_nx = mem_wdata;
        rdata_nx = rdata;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    addr_nx  = addr;
                    wdata_nx = wdata[7:0];
                    cnt_nx   = CNT_LOAD;
                    rd_nx    = ~we;
                    wr_nx    = we;
                    busy_nx  = 1'b1;
                    state_nx = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt == '0) begin
                    if (mem_rd) begin
                        rdata_nx = {8'h00, mem_rdata};
                    end
                    rd_nx    = 1'b0;
                    wr_nx    = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = ST_DONE;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            ST_DONE: begin
                busy_nx  = 1'b0;
                state_nx = ST_IDLE;
            end
            default: begin
                busy_nx  = 1'b0;
                rd_nx    = 1'b0;
                wr_nx    = 1'b0;
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench: five sequencer instances (WAIT_CYCLES 1,2,4,15,0) driven against
// a cycle-timeline reference model and a behavioural byte memory.
module tb_dmem_access_ctrl;

    localparam int unsigned N = 5;

    logic        clk;
    logic        rst       [N];
    logic        req       [N];
    logic        we        [N];
    logic [7:0]  addr      [N];
    logic [15:0] wdata     [N];
    logic        busy      [N];
    logic        done      [N];
    logic [15:0] rdata     [N];
    logic [7:0]  mem_addr  [N];
    logic [7:0]  mem_wdata [N];
    logic        mem_rd    [N];
    logic        mem_wr    [N];
    logic [7:0]  mem_rdata [N];

    // Physical memory behind each instance plus the model's view of it
    bit   [7:0]  mem_data    [N][256];
    bit          mem_written [N][256];
    logic [7:0]  ref_mem     [N][256];
    logic [15:0] exp_rdata   [N];
    logic [7:0]  seed;

    int errors = 0;
    int checks = 0;

    function automatic int eff_w(input int k);
        case (k)
            0: return 1;
            1: return 2;
            2: return 4;
            3: return 15;
            default: return 1;
        endcase
    endfunction

    function automatic logic [7:0] init_byte(input int k, input logic [7:0] a);
        return seed ^ a ^ 8'(k * 37);
    endfunction

    function automatic logic [7:0] phys_read(input int k, input logic [7:0] a);
        return mem_written[k][a] ? mem_data[k][a] : init_byte(k, a);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_access_ctrl #(
            .ADDR_W     (8),
            .WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 15 : 0)
        ) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .req      (req[g]),
            .we       (we[g]),
            .addr     (addr[g]),
            .wdata    (wdata[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .rdata    (rdata[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rd   (mem_rd[g]),
            .mem_wr   (mem_wr[g]),
            .mem_rdata(mem_rdata[g])
        );
        // Data is only valid while mem_rd is high; otherwise return the complement
        assign mem_rdata[g] = mem_rd[g] ? phys_read(g, mem_addr[g]) : ~phys_read(g, mem_addr[g]);
    end

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (mem_wr[k]) begin
                mem_data[k][mem_addr[k]]    <= mem_wdata[k];
                mem_written[k][mem_addr[k]] <= 1'b1;
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle(input int k, input string tag);
        chk($sformatf("%s k%0d busy", tag, k), 16'(busy[k]), 16'h0);
        chk($sformatf("%s k%0d done", tag, k), 16'(done[k]), 16'h0);
        chk($sformatf("%s k%0d rd", tag, k), 16'(mem_rd[k]), 16'h0);
        chk($sformatf("%s k%0d wr", tag, k), 16'(mem_wr[k]), 16'h0);
        chk($sformatf("%s k%0d rdata", tag, k), rdata[k], exp_rdata[k]);
    endtask

    // One access from an IDLE negedge; noisy keeps req high with another address while busy
    task automatic do_access(input int k, input logic w, input logic [7:0] a,
                             input logic [15:0] d, input logic noisy);
        int wc = eff_w(k);
        req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
        for (int i = 1; i <= wc + 1; i++) begin
            @(posedge clk); @(negedge clk);
            if (i == 1) begin
                req[k]   = noisy;
                we[k]    = 1'($urandom);
                addr[k]  = (a == 8'h20) ? 8'h21 : 8'h20;
                wdata[k] = 16'($urandom);
            end
            if (i == wc + 1 && !w) exp_rdata[k] = {8'h00, ref_mem[k][a]};
            chk($sformatf("acc k%0d c%0d rd", k, i), 16'(mem_rd[k]), 16'((i <= wc) && !w));
            chk($sformatf("acc k%0d c%0d wr", k, i), 16'(mem_wr[k]), 16'((i <= wc) && w));
            chk($sformatf("acc k%0d c%0d busy", k, i), 16'(busy[k]), 16'h1);
            chk($sformatf("acc k%0d c%0d done", k, i), 16'(done[k]), 16'(i == wc + 1));
            chk($sformatf("acc k%0d c%0d maddr", k, i), 16'(mem_addr[k]), 16'(a));
            chk($sformatf("acc k%0d c%0d mwdata", k, i), 16'(mem_wdata[k]), 16'(d[7:0]));
            chk($sformatf("acc k%0d c%0d rdata", k, i), rdata[k], exp_rdata[k]);
        end
        if (w) ref_mem[k][a] = d[7:0];
        @(posedge clk); @(negedge clk);
        chk_idle(k, "post");
        chk($sformatf("post k%0d maddr", k), 16'(mem_addr[k]), 16'(a));
        req[k] = 1'b0;
    endtask

    initial begin
        seed = 8'($urandom);
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0; addr[k] = 8'h00; wdata[k] = 16'h0000;
            exp_rdata[k] = 16'h0000;
            for (int a = 0; a < 256; a++) ref_mem[k][a] = init_byte(k, 8'(a));
        end

        // Reset held two cycles, then ten idle cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk_idle(k, "rst");
            chk($sformatf("rst k%0d maddr", k), 16'(mem_addr[k]), 16'h0);
            chk($sformatf("rst k%0d mwdata", k), 16'(mem_wdata[k]), 16'h0);
            rst[k] = 1'b0;
        end
        repeat (10) begin
            @(posedge clk); @(negedge clk);
            for (int k = 0; k < N; k++) chk_idle(k, "idle");
        end

        // Directed sequence on WAIT_CYCLES=2
        do_access(1, 1'b0, 8'h3C, 16'h0000, 1'b0);
        do_access(1, 1'b1, 8'h10, 16'hBE7F, 1'b0);
        do_access(1, 1'b0, 8'h10, 16'h0000, 1'b0);
        chk("st-ld rdata", rdata[1], 16'h007F);
        // Request held through ACCESS/DONE is ignored, then accepted once idle
        do_access(1, 1'b0, 8'h3C, 16'h0000, 1'b1);
        do_access(1, 1'b0, 8'h20, 16'h0000, 1'b0);
        do_access(1, 1'b1, 8'hFF, 16'h12C3, 1'b0);
        do_access(1, 1'b0, 8'hFF, 16'h0000, 1'b0);
        chk("ff rdata", rdata[1], 16'h00C3);

        // Boundary wait counts, including 0 behaving as 1
        do_access(0, 1'b0, 8'hFF, 16'h0000, 1'b0);
        do_access(3, 1'b1, 8'h00, 16'h77AA, 1'b0);
        do_access(3, 1'b0, 8'h00, 16'h0000, 1'b0);
        do_access(4, 1'b0, 8'h81, 16'h0000, 1'b0);

        // Reset mid-access on WAIT_CYCLES=4
        do_access(2, 1'b1, 8'h33, 16'h005A, 1'b0);
        do_access(2, 1'b0, 8'h33, 16'h0000, 1'b0);
        chk("pre-abort rdata", rdata[2], 16'h005A);
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = 8'h44;
        @(posedge clk); @(negedge clk);
        chk("abort strobe up", 16'(mem_rd[2]), 16'h1);
        rst[2] = 1'b1; req[2] = 1'b0;
        @(posedge clk); @(negedge clk);
        exp_rdata[2] = 16'h0000;
        rst[2] = 1'b0;
        chk_idle(2, "abort");
        chk("abort maddr", 16'(mem_addr[2]), 16'h0);
        repeat (6) begin
            @(posedge clk); @(negedge clk);
            chk_idle(2, "abort-quiet");
        end
        do_access(2, 1'b0, 8'h33, 16'h0000, 1'b0);
        chk("post-abort rdata", rdata[2], 16'h005A);

        // Randomized accesses on every instance
        for (int k = 0; k < N; k++) begin
            for (int n = 0; n < 12; n++) begin
                do_access(k, 1'($urandom), 8'($urandom), 16'($urandom),
                          ($urandom_range(0, 3) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
